// File: rtl/cla_seq_adder.sv
// Sequential wide adder/subtractor: one shared 4-bit carry-lookahead slice, one nibble per cycle, LSB first.
// Optional macro CLA_SEQ_OVERFLOW_EN adds a registered signed-overflow output `ovf`.

module carry_lookahead_four (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:1] c,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat two-level function of g, p and cin; nothing ripples.
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
endmodule

module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef CLA_SEQ_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             busy
);
  localparam int SLICES = WIDTH / 4;
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cout_q, cout_d;
  logic               start_ready_q, start_ready_d;
  logic               result_valid_q, result_valid_d;
  logic               busy_q, busy_d;
`ifdef CLA_SEQ_OVERFLOW_EN
  logic               ovf_q, ovf_d;
`endif

  logic [3:1] slice_c;
  logic       slice_cout;
  logic [3:0] nib_sum;

  carry_lookahead_four u_slice (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .cin  (carry_q),
    .c    (slice_c),
    .cout (slice_cout)
  );

  assign nib_sum = a_q[3:0] ^ b_q[3:0] ^ {slice_c, carry_q};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    cout_d    = cout_q;
`ifdef CLA_SEQ_OVERFLOW_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          // Subtraction is a + ~b + 1; the forced carry-in replaces cin.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = {nib_sum, sum_q[WIDTH-1:4]};
        a_d     = {4'b0, a_q[WIDTH-1:4]};
        b_d     = {4'b0, b_q[WIDTH-1:4]};
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          cout_d  = slice_cout;
`ifdef CLA_SEQ_OVERFLOW_EN
          ovf_d   = slice_c[3] ^ slice_cout;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    start_ready_d  = (state_d == IDLE);
    result_valid_d = (state_d == DONE);
    busy_d         = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      a_q            <= '0;
      b_q            <= '0;
      sum_q          <= '0;
      carry_q        <= 1'b0;
      cnt_q          <= '0;
      cout_q         <= 1'b0;
      start_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
`ifdef CLA_SEQ_OVERFLOW_EN
      ovf_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      b_q            <= b_d;
      sum_q          <= sum_d;
      carry_q        <= carry_d;
      cnt_q          <= cnt_d;
      cout_q         <= cout_d;
      start_ready_q  <= start_ready_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
`ifdef CLA_SEQ_OVERFLOW_EN
      ovf_q          <= ovf_d;
`endif
    end
  end

  assign start_ready  = start_ready_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign sum          = sum_q;
  assign cout         = cout_q;
`ifdef CLA_SEQ_OVERFLOW_EN
  assign ovf          = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder: arithmetic reference model plus directed vectors with literal results.
// Honours CLA_SEQ_OVERFLOW_EN the same way the design does.

module tb_cla_seq_adder;
  localparam int W      = 16;
  localparam int SLICES = W / 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         result_valid;
  logic         result_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef CLA_SEQ_OVERFLOW_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .cin          (cin),
    .sub          (sub),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .sum          (sum),
    .cout         (cout),
`ifdef CLA_SEQ_OVERFLOW_EN
    .ovf          (ovf),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic; result packed as {ovf, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, mb, input logic mcin, msub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         v;
    bb   = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (msub ? 1'b1 : mcin)};
    v    = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
    return {v, full};
  endfunction

  // Scoreboard: records the expected result at every accepted request.
  logic [W+1:0] exp_res;
  logic         exp_pending = 1'b0;
  int           cyc = 0;
  int           acc_cyc = 0;
  logic         prev_valid = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_pending <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (result_valid && result_ready) exp_pending <= 1'b0;
      if (start_valid && start_ready) begin
        exp_res     <= model(a, b, cin, sub);
        exp_pending <= 1'b1;
        acc_cyc     <= cyc + 1;
      end
    end
  end

  // Compare process: every falling edge outside reset.
  always @(negedge clk) begin
    if (reset_n) begin
      if (result_valid) begin
        if (!exp_pending) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got result_valid=1 want 0 (t=%0t)", $time);
        end else begin
          check("model_sum", 32'(sum), 32'(exp_res[W-1:0]));
          check("model_cout", 32'(cout), 32'(exp_res[W]));
`ifdef CLA_SEQ_OVERFLOW_EN
          check("model_ovf", 32'(ovf), 32'(exp_res[W+1]));
`endif
          if (!prev_valid) check("latency", 32'(cyc - acc_cyc), 32'(SLICES));
        end
      end else if (exp_pending) begin
        check("run_busy", 32'(busy), 32'd1);
        check("run_start_ready", 32'(start_ready), 32'd0);
      end
      prev_valid <= result_valid;
    end else begin
      prev_valid <= 1'b0;
    end
  end

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (result_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL result_timeout: got no result_valid within 20 cycles (t=%0t)", $time);
    end
  endtask

  task automatic do_op(input logic [W-1:0] ta, tb, input logic tcin, tsub,
                       input logic [W-1:0] esum, input logic ecout, eovf, input bit early_rr);
    bit ok;
    @(negedge clk);
    a = ta; b = tb; cin = tcin; sub = tsub;
    start_valid  = 1'b1;
    result_ready = early_rr;
    @(negedge clk);
    start_valid = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_start_ready", 32'(start_ready), 32'd0);
    wait_valid(ok);
    if (ok) begin
      check("vec_sum", 32'(sum), 32'(esum));
      check("vec_cout", 32'(cout), 32'(ecout));
`ifdef CLA_SEQ_OVERFLOW_EN
      check("vec_ovf", 32'(ovf), 32'(eovf));
`else
      if (eovf === 1'bx) $display("note: ovf expectation undefined");
`endif
    end
    result_ready = 1'b1;
    @(negedge clk);
    check("release_start_ready", 32'(start_ready), 32'd1);
    check("release_result_valid", 32'(result_valid), 32'd0);
    check("release_busy", 32'(busy), 32'd0);
    result_ready = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] va, vb;
    logic         vcin, vsub;
    logic [W-1:0] vsum;
    logic         vcout, vovf;
    bit           early;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit ok;
    reset_n = 1'b1; start_valid = 1'b0; result_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{16'h0007, 16'h0007, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};

    // Asynchronous reset asserted mid-cycle takes effect without a clock edge.
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'h0);
    check("rst_cout", 32'(cout), 32'd0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub,
            vecs[i].vsum, vecs[i].vcout, vecs[i].vovf, vecs[i].early);

    // Backpressure: DONE held while start_valid stays high and operands churn.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
    start_valid = 1'b1; result_ready = 1'b0;
    wait_valid(ok);
    for (int i = 0; i < 10; i++) begin
      check("bp_result_valid", 32'(result_valid), 32'd1);
      check("bp_start_ready", 32'(start_ready), 32'd0);
      check("bp_sum", 32'(sum), 32'h3333);
      check("bp_cout", 32'(cout), 32'd0);
      a = W'($urandom); b = W'($urandom); sub = i[0];
      @(negedge clk);
    end
    a = 16'h0100; b = 16'h0200; cin = 1'b0; sub = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_start_ready", 32'(start_ready), 32'd1);
    check("bp_idle_result_valid", 32'(result_valid), 32'd0);
    result_ready = 1'b0;
    @(negedge clk);
    check("bp_pending_accepted", 32'(busy), 32'd1);
    start_valid = 1'b0;
    wait_valid(ok);
    if (ok) check("bp_second_sum", 32'(sum), 32'h0300);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;

    // Leave cout=1 so the mid-operation reset visibly clears it.
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    a = 16'h00FF; b = 16'h0F0F; cin = 1'b0; sub = 1'b0;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_start_ready", 32'(start_ready), 32'd1);
    check("midrst_result_valid", 32'(result_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sum", 32'(sum), 32'h0);
    check("midrst_cout", 32'(cout), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abandoned_no_result", 32'(result_valid), 32'd0);
    check("abandoned_idle", 32'(start_ready), 32'd1);

    do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
